// File: rtl/gauss_pkg.sv
// Shared types and constants for the streaming binomial smoother.
// Kernel weights and widths are derived from the kernel size (3 or 5).
package gauss_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Binomial tap weight i of a ksize-tap kernel (1 2 1 or 1 4 6 4 1).
  function automatic int binom_w(input int ksize, input int i);
    if (ksize == 3) begin
      case (i)
        0, 2:    return 1;
        1:       return 2;
        default: return 0;
      endcase
    end else begin
      case (i)
        0, 4:    return 1;
        1, 3:    return 4;
        2:       return 6;
        default: return 0;
      endcase
    end
  endfunction

  function automatic int vsum_growth(input int ksize);
    return (ksize == 3) ? 2 : 4;
  endfunction

  function automatic int round_shift(input int ksize);
    return 2 * vsum_growth(ksize);
  endfunction

endpackage

// File: rtl/gauss_vsum.sv
// Stage 1 of the smoother: binomial-weighted vertical sum of one column,
// built from shifts and adds and registered when a column is accepted.
module gauss_vsum
  import gauss_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int KSIZE = 5,
  parameter int VW    = PIX_W + vsum_growth(KSIZE)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load,
  input  logic [KSIZE*PIX_W-1:0] i_col,
  output logic [VW-1:0]          o_v
);

  logic [VW-1:0] p [KSIZE];
  logic [VW-1:0] v_next;

  // Row 0 is the top row, which sits in the MSBs of the column word.
  always_comb begin
    for (int i = 0; i < KSIZE; i++)
      p[i] = VW'(i_col[(KSIZE-1-i)*PIX_W +: PIX_W]);
  end

  if (KSIZE == 3) begin : g_k3
    assign v_next = p[0] + (p[1] << 1) + p[2];
  end else if (KSIZE == 5) begin : g_k5
    assign v_next = p[0] + (p[1] << 2) + (p[2] << 2) + (p[2] << 1) + (p[3] << 2) + p[4];
  end else begin : g_bad
    $error("gauss_vsum: KSIZE must be 3 or 5");
    assign v_next = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      o_v <= '0;
    else if (i_load)
      o_v <= v_next;
  end

endmodule

// File: rtl/gauss_smooth_stream.sv
// Streaming separable binomial smoother: FSM, column counter, window and
// horizontal stage. Define GAUSS_EDGE_REPLICATE_EN for edge-replicate padding.
module gauss_smooth_stream
  import gauss_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int WIDTH = 640,
  parameter int KSIZE = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [KSIZE*PIX_W-1:0] i_col,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_en,
  output logic [PIX_W-1:0]       o_pixel,
  output logic                   o_valid,
  output logic                   o_sol,
  output logic                   o_eol
);

  localparam int R  = (KSIZE - 1) / 2;
  localparam int VW = PIX_W + vsum_growth(KSIZE);
  localparam int SH = round_shift(KSIZE);
  localparam int SW = PIX_W + SH;
  localparam int IW = $clog2(WIDTH + KSIZE) + 1;

  if (WIDTH < KSIZE) begin : g_bad_width
    $error("gauss_smooth_stream: WIDTH must be >= KSIZE");
  end

  typedef struct packed {
    logic [VW-1:0]    v;
    logic [PIX_W-1:0] pix;
    logic             en;
  } slot_t;

  state_t           state;
  logic [IW-1:0]    col_cnt;
  logic             accept;
  logic [VW-1:0]    vsum_v;
  logic             s1_valid, s1_pad, s1_en;
  logic [IW-1:0]    s1_idx;
  logic [PIX_W-1:0] s1_pix;
  slot_t            win [KSIZE];
  slot_t            new_slot, left_fill;
  logic [VW-1:0]    pad_v;
  logic             s2_valid, s2_sol, s2_eol;
  logic [SW-1:0]    hsum, rounded;
  logic [PIX_W-1:0] smooth_pix;
  logic [SH-1:0]    unused_round_lsbs;

  assign accept = i_valid & o_ready;

  // During FLUSH col_cnt keeps counting past WIDTH-1 and names the pad columns.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_RUN;
      o_ready <= 1'b1;
      col_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            col_cnt <= col_cnt + IW'(1);
            if (col_cnt == IW'(WIDTH - 1)) begin
              state   <= ST_FLUSH;
              o_ready <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          if (col_cnt == IW'(WIDTH + R - 1)) begin
            state   <= ST_RUN;
            o_ready <= 1'b1;
            col_cnt <= '0;
          end else begin
            col_cnt <= col_cnt + IW'(1);
          end
        end
        default: begin
          state   <= ST_RUN;
          o_ready <= 1'b1;
          col_cnt <= '0;
        end
      endcase
    end
  end

  gauss_vsum #(
    .PIX_W (PIX_W),
    .KSIZE (KSIZE),
    .VW    (VW)
  ) u_vsum (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (accept),
    .i_col  (i_col),
    .o_v    (vsum_v)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_pad   <= 1'b0;
      s1_idx   <= '0;
      s1_pix   <= '0;
      s1_en    <= 1'b0;
    end else begin
      s1_valid <= accept | (state == ST_FLUSH);
      s1_pad   <= (state == ST_FLUSH);
      s1_idx   <= col_cnt;
      if (accept) begin
        s1_pix <= i_col[(KSIZE-1-R)*PIX_W +: PIX_W];
        s1_en  <= i_en;
      end
    end
  end

  always_comb begin
    left_fill = '0;
`ifdef GAUSS_EDGE_REPLICATE_EN
    left_fill.v = vsum_v;
    pad_v       = win[KSIZE-1].v;
`else
    pad_v       = '0;
`endif
    new_slot.v   = s1_pad ? pad_v : vsum_v;
    new_slot.pix = s1_pix;
    new_slot.en  = s1_en;
  end

  // Column 0 refills the left slots so the previous line never leaks in.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int j = 0; j < KSIZE; j++)
        win[j] <= '0;
      s2_valid <= 1'b0;
      s2_sol   <= 1'b0;
      s2_eol   <= 1'b0;
    end else begin
      s2_valid <= s1_valid && (s1_idx >= IW'(R));
      s2_sol   <= s1_valid && (s1_idx == IW'(R));
      s2_eol   <= s1_valid && (s1_idx == IW'(WIDTH - 1 + R));
      if (s1_valid) begin
        if (!s1_pad && (s1_idx == '0)) begin
          for (int j = 0; j < KSIZE - 1; j++)
            win[j] <= left_fill;
        end else begin
          for (int j = 0; j < KSIZE - 1; j++)
            win[j] <= win[j+1];
        end
        win[KSIZE-1] <= new_slot;
      end
    end
  end

  always_comb begin
    hsum = '0;
    for (int j = 0; j < KSIZE; j++)
      hsum = hsum + SW'(binom_w(KSIZE, j)) * SW'(win[j].v);
  end

  assign rounded = hsum + (SW'(1) << (SH - 1));
  assign {smooth_pix, unused_round_lsbs} = rounded;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pixel <= '0;
      o_valid <= 1'b0;
      o_sol   <= 1'b0;
      o_eol   <= 1'b0;
    end else begin
      o_valid <= s2_valid;
      o_sol   <= s2_valid & s2_sol;
      o_eol   <= s2_valid & s2_eol;
      if (s2_valid)
        o_pixel <= win[R].en ? smooth_pix : win[R].pix;
    end
  end

endmodule

// File: doc/gauss_smooth_stream.md
# gauss_smooth_stream

Parametrised streaming Gaussian smoother for the feature-detection front end: accepts one vertical pixel column per beat from the line-buffer, applies a separable binomial kernel (3×3 or 5×5), and emits one centred, rounded pixel per input column. It adds line-boundary padding, an end-of-line flush with backpressure, and a runtime bypass. It feeds the corner/descriptor stages.

## Interface
- `PIX_W`, 8: bits per pixel.
- `WIDTH`, 640: pixels per line; must be ≥ `KSIZE`.
- `KSIZE`, 5: kernel size. Only 3 or 5 is legal; any other value is an elaboration error. `R` = (`KSIZE`−1)/2.
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_col`  in  `KSIZE`*`PIX_W`  one column, top row in the MSBs.
- `i_valid`  in  1  column valid.
- `o_ready`  out  1  block can accept a column; registered.
- `i_en`  in  1  1 = smooth, 0 = bypass; sampled along with each column.
- `o_pixel`  out  `PIX_W`  output pixel; registered.
- `o_valid`  out  1  output valid; registered.
- `o_sol` / `o_eol`  out  1  asserted with the output for centre 0 / centre `WIDTH`−1.

## Operation
- **Accept:** a column is accepted when `i_valid` & `o_ready`. While `o_ready`=0, `i_valid` is ignored and the column is lost.
- **Vertical sum:** V = Σ bᵢ·pᵢ.
  - Weights b are 1 2 1 (`KSIZE`=3) or 1 4 6 4 1 (`KSIZE`=5).
  - V width is `PIX_W`+2 or `PIX_W`+4.
- **Column counter:** `col_cnt` runs 0..`WIDTH`−1 on each accept.
- **Horizontal sum:** the output for centre c is S = Σⱼ hⱼ·V(c−R+j), with h = b.
  - S width is `PIX_W`+4 or `PIX_W`+8.
  - `o_pixel` = (S + 2^(SH−1)) >> SH, where SH = 4 or 8.
  - No saturation is needed; the result never exceeds 2^`PIX_W`−1.
- **Padding:** V(x) for x<0 or x>`WIDTH`−1 is the pad value (see Configuration).
- **Bypass:** when the centre column was accepted with `i_en`=0, `o_pixel` is that column's centre-row pixel. Latency, framing and flags are identical to smoothing mode.
- **State machine:** two states, RUN and FLUSH.
  - RUN: `o_ready`=1.
  - Accepting column `WIDTH`−1 moves RUN→FLUSH.
  - FLUSH: `o_ready`=0 for exactly R cycles. Each cycle injects one pad column into the pipeline. `col_cnt` is cleared and the state returns to RUN.
- **Line start:** columns 0..R−1 produce no output. Accepting column c+R produces the output for centre c.
- **Output count:** exactly `WIDTH` outputs per line; `o_sol` and `o_eol` each assert once per line.
- **Bubbles:** `i_valid`=0 in RUN is a bubble. The window does not shift and no output is produced.
- **Reset mid-line:**
  - The partial line is discarded.
  - The next accepted column is treated as column 0 of a new line.

## Timing
- **Reset values:**
  - `o_pixel`=0, `o_valid`=0, `o_sol`=0, `o_eol`=0.
  - `o_ready`=1, state RUN, `col_cnt`=0.
  - All window registers 0.
- **Pipeline:** three register stages (vertical sum, window shift, horizontal sum/round). `o_valid` asserts on the 3rd rising edge after the accepting edge, or after the FLUSH injection edge.
- **Throughput:** one output per cycle during back-to-back input and during FLUSH. Sustained rate is `WIDTH` outputs per `WIDTH`+R cycles.
- **FLUSH/new-line boundary:**
  - A column presented in the last FLUSH cycle is not accepted.
  - The first accept of the next line occurs the cycle after `o_ready` rises.
  - Outputs from the flush and from the new line never coincide.

## Configuration
- **`GAUSS_EDGE_REPLICATE_EN` defined:**
  - Pad columns replicate the edge: V(x<0)=V(0) and V(x>`WIDTH`−1)=V(`WIDTH`−1).
  - On accepting column 0, all left window slots load V(0).
- **Undefined:** pad columns are V=0 (zero padding).
- **Bypass:** the macro has no effect on bypass output.

## Structure
- **`gauss_pkg`:**
  - state enum (RUN, FLUSH);
  - weight function `binom_w(KSIZE, i)`;
  - width/shift constants derived from `KSIZE`.
- **Sub-module `gauss_vsum`:**
  - parametrised vertical weighted sum;
  - output registered as stage 1;
  - weights built from shifts and adds, no multipliers.
- The top level holds the FSM, counter, window and horizontal stage.

## Test plan
- **Flat field:** `KSIZE`=5, `WIDTH`=16, all pixels 100, replicate on → 16 outputs all 100; `o_sol` on the 1st output, `o_eol` on the 16th; `o_ready` low 2 cycles after column 15.
- **Flat field, zero padding:** same stimulus, macro undefined → centre 0 = 69, centre 1 = 94, centres 2..13 = 100, centre 14 = 94, centre 15 = 69.
- **Impulse:** 255 at column 10, centre row, all else 0 (`KSIZE`=5):
  - centre 10 = 36;
  - centre 8 = 6;
  - first `o_valid` arrives 3 cycles after column 2 is accepted.
- **Bubbles and back-to-back lines:** random `i_valid` gaps within a line plus back-to-back lines → output stream matches the golden model. `i_valid` held high during FLUSH is not consumed; the next line starts correctly.
- **Bypass:** `i_en`=0 for columns 4..6 → `o_pixel` equals those columns' centre pixels at the same latency.
- **Reset mid-line:** assert `i_rst` after column 7 → outputs zero, `o_ready`=1; the next line produces exactly `WIDTH` outputs.
